// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings and constants for the EX-stage multiply/divide unit.
package mips_pkg;

  localparam int WORD_W   = 32;
  localparam int MDU_ITER = 32;

  // op encodings: bit 1 selects divide, bit 0 selects signed
  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } mdu_state_t;

endpackage

// File: rtl/mdu_cond_neg.sv
// mdu_cond_neg: conditional two's-complement of a W-bit value.
// Used both to take operand magnitudes and to re-apply result signs.
module mdu_cond_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  // Negate when requested, otherwise pass the value through untouched.
  always_comb begin
    if (i_neg) begin
      o_val = ~i_val + {{(W-1){1'b0}}, 1'b1};
    end else begin
      o_val = i_val;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Sequence: IDLE -> RUN (32 radix-2 steps) -> FIX (sign fix + writeback).
// Build option: define MDU_DIV_EN to build the divide datapath; without it
// DIV/DIVU issues are silently refused and only multiplies run.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] write_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [4:0] CNT_LAST = 5'(MDU_ITER - 1);

  mdu_state_t         r_state;
  logic [4:0]         r_cnt;
  logic [2*WIDTH-1:0] r_acc;      // {partial product | remainder, multiplier | quotient}
  logic [WIDTH-1:0]   r_opnd;     // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_neg_res;  // product / quotient must be negated
`ifdef MDU_DIV_EN
  logic               r_is_div;
  logic               r_neg_rem;  // remainder follows the dividend sign
  logic               r_div0;
`endif

  logic               w_signed;
  logic               w_is_div_op;
  logic               w_accept;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_hi_res;
  logic [WIDTH-1:0]   w_lo_res;
`ifdef MDU_DIV_EN
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_step;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
`endif

  assign w_signed    = op[0];
  assign w_is_div_op = op[1];

  // Operand magnitudes; unsigned ops pass raw values straight through.
  mdu_cond_neg #(.W(WIDTH)) u_abs_a (
    .i_val (src_a),
    .i_neg (w_signed & src_a[WIDTH-1]),
    .o_val (w_abs_a)
  );

  mdu_cond_neg #(.W(WIDTH)) u_abs_b (
    .i_val (src_b),
    .i_neg (w_signed & src_b[WIDTH-1]),
    .o_val (w_abs_b)
  );

  // Issue qualification: only from IDLE, cancel beats start, divides refused when not built.
  always_comb begin
    w_accept = 1'b0;
    if (start && !cancel && (r_state == IDLE)) begin
`ifdef MDU_DIV_EN
      w_accept = 1'b1;
`else
      w_accept = !w_is_div_op;
`endif
    end else begin
      w_accept = 1'b0;
    end
  end

  // One radix-2 shift-add multiply step: add multiplicand if LSB set, then shift right.
  always_comb begin
    w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + ({1'b0, r_opnd} & {(WIDTH+1){r_acc[0]}});
    w_mul_step = {w_add, r_acc[WIDTH-1:1]};
  end

`ifdef MDU_DIV_EN
  // One restoring divide step: shift in next dividend bit, subtract divisor if it fits.
  always_comb begin
    w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_opnd};
    if (!w_diff[WIDTH]) begin
      w_div_step = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_div_step = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
  end

  // Select the iteration step for the operation in flight.
  always_comb begin
    if (r_is_div) begin
      w_step = w_div_step;
    end else begin
      w_step = w_mul_step;
    end
  end
`else
  assign w_step = w_mul_step;
`endif

  // Sign fix for the full 64-bit product.
  mdu_cond_neg #(.W(2*WIDTH)) u_fix_prod (
    .i_val (r_acc),
    .i_neg (r_neg_res),
    .o_val (w_prod_fix)
  );

`ifdef MDU_DIV_EN
  // Quotient sign fix is suppressed on divide-by-zero so LO stays all ones.
  mdu_cond_neg #(.W(WIDTH)) u_fix_quo (
    .i_val (r_acc[WIDTH-1:0]),
    .i_neg (r_neg_res & ~r_div0),
    .o_val (w_quo_fix)
  );

  // Remainder takes the dividend sign; on divide-by-zero this restores src_a exactly.
  mdu_cond_neg #(.W(WIDTH)) u_fix_rem (
    .i_val (r_acc[2*WIDTH-1:WIDTH]),
    .i_neg (r_neg_rem),
    .o_val (w_rem_fix)
  );
`endif

  // Writeback values for HI/LO at the end of an operation.
  always_comb begin
    w_hi_res = w_prod_fix[2*WIDTH-1:WIDTH];
    w_lo_res = w_prod_fix[WIDTH-1:0];
`ifdef MDU_DIV_EN
    if (r_is_div) begin
      w_hi_res = w_rem_fix;
      if (r_div0) begin
        w_lo_res = {WIDTH{1'b1}};
      end else begin
        w_lo_res = w_quo_fix;
      end
    end else begin
      w_hi_res = w_prod_fix[2*WIDTH-1:WIDTH];
      w_lo_res = w_prod_fix[WIDTH-1:0];
    end
`endif
  end

  // Sequencer: operand latch on issue, 32 iteration steps, writeback pulse, cancel abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= 5'd0;
      r_acc     <= {(2*WIDTH){1'b0}};
      r_opnd    <= {WIDTH{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_neg_res <= 1'b0;
`ifdef MDU_DIV_EN
      r_is_div  <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= RUN;
            r_busy    <= 1'b1;
            r_cnt     <= 5'd0;
            r_neg_res <= w_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
`ifdef MDU_DIV_EN
            r_is_div  <= w_is_div_op;
            r_neg_rem <= w_signed & src_a[WIDTH-1];
            r_div0    <= (src_b == {WIDTH{1'b0}});
            if (w_is_div_op) begin
              r_opnd <= w_abs_b;
              r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
            end else begin
              r_opnd <= w_abs_a;
              r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
            end
`else
            r_opnd    <= w_abs_a;
            r_acc     <= {{WIDTH{1'b0}}, w_abs_b};
`endif
          end
        end
        RUN: begin
          if (cancel) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= 5'd0;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == CNT_LAST) begin
              r_state <= FIX;
            end
          end
        end
        FIX: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= !cancel;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Architectural HI/LO: MTHI/MTLO accepted only in IDLE, results land in FIX unless cancelled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= {WIDTH{1'b0}};
      r_lo <= {WIDTH{1'b0}};
    end else if (r_state == FIX) begin
      if (!cancel) begin
        r_hi <= w_hi_res;
        r_lo <= w_lo_res;
      end
    end else if (r_state == IDLE) begin
      if (hi_we) begin
        r_hi <= write_val;
      end
      if (lo_we) begin
        r_lo <= write_val;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized self-checking bench for mult_div_unit.
// Divide scenarios are exercised when MDU_DIV_EN is defined; otherwise the
// refused-divide behaviour is checked instead.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        cancel = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] write_val = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .cancel    (cancel),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .write_val (write_val),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  // Reference: MIPS HI/LO result from plain integer arithmetic, returned as {HI, LO}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: r = ua * ub;
      2'b01: r = 64'(sa * sb);
      2'b10: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
      2'b11: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Issue one op (caller sits on a negedge) and observe until done or a 40-cycle bound.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cnt, output int done_cnt, output int done_idx);
    busy_cnt = 0;
    done_cnt = 0;
    done_idx = -1;
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_idx = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #3;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=00000000", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=00000000", lo); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu_corner();
    int bc, dc, di;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc, di);
    checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_max_hi got=%h exp=fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_max_lo got=%h exp=00000001", lo); end
    checks++; if (bc != 33) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=33", bc); end
    checks++; if (di != 33) begin failures++; $display("FAIL multu_done_edge got=%0d exp=33", di); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL multu_busy_with_done got=%b exp=0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL multu_done_width got=%b exp=0", done); end
  endtask

  task automatic test_mult_neg();
    int bc, dc, di;
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, bc, dc, di);
    checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_neg_lo got=%h exp=ffffffeb", lo); end
    checks++; if (dc != 1) begin failures++; $display("FAIL mult_neg_done got=%0d exp=1", dc); end
  endtask

  task automatic test_random_mul();
    int bc, dc, di;
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if (i == 0) begin a = 32'h8000_0000; b = 32'h8000_0000; end
      if (i == 1) begin a = 32'd0; b = $urandom; end
      if (i == 2) begin a = 32'h7FFF_FFFF; b = 32'h8000_0000; end
      exp = model(o, a, b);
      run_op(o, a, b, bc, dc, di);
      checks++;
      if ({hi, lo} !== exp) begin
        failures++;
        $display("FAIL rand_mul op=%0d a=%h b=%h got=%h_%h exp=%h", o, a, b, hi, lo, exp);
      end
    end
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div();
    int bc, dc, di;
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp;
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, bc, dc, di);
    checks++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin failures++; $display("FAIL div_m7_2 got=%h_%h exp=ffffffff_fffffffd", hi, lo); end
    run_op(2'b10, 32'd100, 32'd0, bc, dc, di);
    checks++; if ({hi, lo} !== {32'd100, 32'hFFFF_FFFF}) begin failures++; $display("FAIL divu_by_zero got=%h_%h exp=00000064_ffffffff", hi, lo); end
    checks++; if (di != 33) begin failures++; $display("FAIL divu_done_edge got=%0d exp=33", di); end
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc, di);
    checks++; if ({hi, lo} !== {32'd0, 32'h8000_0000}) begin failures++; $display("FAIL div_overflow got=%h_%h exp=00000000_80000000", hi, lo); end
    run_op(2'b11, 32'hFFFF_FF00, 32'd0, bc, dc, di);
    checks++; if ({hi, lo} !== {32'hFFFF_FF00, 32'hFFFF_FFFF}) begin failures++; $display("FAIL div_neg_by_zero got=%h_%h exp=ffffff00_ffffffff", hi, lo); end
    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom_range(2, 3));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      if ($urandom_range(0, 1) == 1) b = -b;
      exp = model(o, a, b);
      run_op(o, a, b, bc, dc, di);
      checks++;
      if ({hi, lo} !== exp) begin
        failures++;
        $display("FAIL rand_div op=%0d a=%h b=%h got=%h_%h exp=%h", o, a, b, hi, lo, exp);
      end
    end
  endtask
`else
  task automatic test_div_disabled();
    int bc, dc, di;
    hi_we = 1'b1; write_val = 32'hA5A5_0001;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; write_val = 32'h5A5A_0002;
    @(negedge clk);
    lo_we = 1'b0;
    run_op(2'b10, 32'd100, 32'd7, bc, dc, di);
    checks++; if (bc != 0) begin failures++; $display("FAIL nodiv_busy got=%0d exp=0", bc); end
    checks++; if (dc != 0) begin failures++; $display("FAIL nodiv_done got=%0d exp=0", dc); end
    checks++; if ({hi, lo} !== {32'hA5A5_0001, 32'h5A5A_0002}) begin failures++; $display("FAIL nodiv_hilo got=%h_%h exp=a5a50001_5a5a0002", hi, lo); end
    run_op(2'b00, 32'd6, 32'd7, bc, dc, di);
    checks++; if ({hi, lo} !== {32'd0, 32'd42}) begin failures++; $display("FAIL nodiv_multu got=%h_%h exp=00000000_0000002a", hi, lo); end
  endtask
`endif

  task automatic test_cancel();
    int dcnt;
    hi_we = 1'b1; lo_we = 1'b1; write_val = 32'hCAFE_0001;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    start = 1'b1; op = 2'b00; src_a = $urandom; src_b = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cancel_busy got=%b exp=0", busy); end
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    checks++; if (dcnt != 0) begin failures++; $display("FAIL cancel_no_done got=%0d exp=0", dcnt); end
    checks++; if ({hi, lo} !== {32'hCAFE_0001, 32'hCAFE_0001}) begin failures++; $display("FAIL cancel_hilo got=%h_%h exp=cafe0001_cafe0001", hi, lo); end
    start = 1'b1; cancel = 1'b1; src_a = 32'd3; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cancel_vs_start got=%b exp=0", busy); end
  endtask

  task automatic test_start_while_busy();
    int di;
    logic [31:0] a, b;
    logic [63:0] exp;
    a = $urandom;
    b = $urandom;
    exp = model(2'b01, a, b);
    start = 1'b1; op = 2'b01; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b00; src_a = ~a; src_b = b ^ 32'h5555_5555;
    repeat (3) @(negedge clk);
    start = 1'b0;
    di = -1;
    for (int i = 8; i < 48; i++) begin
      @(negedge clk);
      if (done) begin di = i; break; end
    end
    checks++; if (di != 33) begin failures++; $display("FAIL busy_start_done_edge got=%0d exp=33", di); end
    checks++; if ({hi, lo} !== exp) begin failures++; $display("FAIL busy_start_result got=%h_%h exp=%h", hi, lo, exp); end
  endtask

  task automatic test_writes();
    int di;
    logic [31:0] a, b;
    logic [63:0] exp;
    hi_we = 1'b1; write_val = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    checks++; if (hi !== 32'h0000_1234) begin failures++; $display("FAIL mthi_idle got=%h exp=00001234", hi); end
    lo_we = 1'b1; write_val = 32'h0000_5678;
    @(negedge clk);
    lo_we = 1'b0;
    checks++; if (lo !== 32'h0000_5678) begin failures++; $display("FAIL mtlo_idle got=%h exp=00005678", lo); end
    a = $urandom; b = $urandom;
    exp = model(2'b00, a, b);
    start = 1'b1; op = 2'b00; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    lo_we = 1'b1; write_val = 32'hDEAD_BEEF;
    @(negedge clk);
    lo_we = 1'b0;
    checks++; if (lo !== 32'h0000_5678) begin failures++; $display("FAIL mtlo_busy got=%h exp=00005678", lo); end
    di = -1;
    for (int i = 3; i < 43; i++) begin
      @(negedge clk);
      if (done) begin di = i; break; end
    end
    checks++; if ({hi, lo} !== exp) begin failures++; $display("FAIL mtlo_busy_result got=%h_%h exp=%h", hi, lo, exp); end
    start = 1'b1; op = 2'b00; src_a = 32'd6; src_b = 32'd7; hi_we = 1'b1; write_val = 32'h0000_0099;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    checks++; if (hi !== 32'h0000_0099) begin failures++; $display("FAIL mthi_with_start got=%h exp=00000099", hi); end
    di = -1;
    for (int i = 1; i < 41; i++) begin
      @(negedge clk);
      if (done) begin di = i; break; end
    end
    checks++; if ({hi, lo} !== {32'd0, 32'd42}) begin failures++; $display("FAIL mthi_overwritten got=%h_%h exp=00000000_0000002a", hi, lo); end
  endtask

  task automatic test_back_to_back();
    int bc, dc, di;
    logic [31:0] a, b;
    logic [63:0] exp;
    run_op(2'b01, $urandom, $urandom, bc, dc, di);
    a = $urandom; b = $urandom;
    exp = model(2'b00, a, b);
    run_op(2'b00, a, b, bc, dc, di);
    checks++; if (bc != 33) begin failures++; $display("FAIL b2b_busy_cycles got=%0d exp=33", bc); end
    checks++; if (di != 33) begin failures++; $display("FAIL b2b_done_edge got=%0d exp=33", di); end
    checks++; if ({hi, lo} !== exp) begin failures++; $display("FAIL b2b_result got=%h_%h exp=%h", hi, lo, exp); end
  endtask

  task automatic test_reset_mid_run();
    hi_we = 1'b1; lo_we = 1'b1; write_val = 32'h0000_1111;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    start = 1'b1; op = 2'b01; src_a = $urandom; src_b = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if ({hi, lo} !== 64'd0) begin failures++; $display("FAIL rst_mid_hilo got=%h_%h exp=0_0", hi, lo); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_release_busy got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_multu_corner();
    test_mult_neg();
    test_random_mul();
`ifdef MDU_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_cancel();
    test_start_while_busy();
    test_writes();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit in the EX stage, directly downstream of the register file. It takes the two register-read operands (rs, rt), runs MIPS MULT/MULTU/DIV/DIVU over 32 iteration cycles, and holds the result in architectural HI/LO registers. It also services MTHI/MTLO writes, and drives `busy` so the hazard logic can stall MFHI/MFLO and further mult/div issue.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is supported.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  issue request; sampled only when `busy`=0.
- op  in  2  operation code: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- src_a  in  WIDTH  rs value (multiplicand or dividend).
- src_b  in  WIDTH  rt value (multiplier or divisor).
- cancel  in  1  pipeline flush; aborts an in-flight operation.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- write_val  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO are updated by an operation.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- FSM states: IDLE, RUN, FIX.
- **IDLE**
  - When `start`=1, latch |src_a| and |src_b|. Magnitudes are used for signed ops; raw values for unsigned ops.
  - Latch result sign flags and `op`, clear the 5-bit counter, and go to RUN.
- **RUN**
  - Multiply: one radix-2 shift-add step per cycle into a 64-bit accumulator.
  - Divide: one restoring shift-subtract step per cycle, producing a 32-bit quotient and remainder.
  - The counter increments each cycle. After step 32 (counter=31), go to FIX.
- **FIX**
  - Apply signs:
    - MULT: negate the 64-bit product when a^b is negative.
    - DIV: negate the quotient when sign(a)≠sign(b); the remainder takes the sign of the dividend.
  - Write results: HI←product[63:32] or remainder; LO←product[31:0] or quotient.
  - Pulse `done` and return to IDLE.
- **Divide by zero:** LO=32'hFFFFFFFF, HI=src_a. This holds for both DIVU and DIV, with no sign fix on HI.
- **DIV 0x80000000 / 0xFFFFFFFF:** LO=0x80000000, HI=0.
- **`start` while busy:** ignored; operands are not re-latched.
- **`cancel`** (any state): go to IDLE next edge with HI/LO unchanged and no `done` pulse. `cancel` and `start` in the same IDLE cycle: `cancel` wins and `start` is dropped.
- **`hi_we`/`lo_we`**
  - In IDLE: update HI/LO from `write_val` at the next edge.
  - While busy: ignored.
  - With `start` in the same cycle: the write lands, and the operation later overwrites it.
- **Reset (asynchronous, mid-operation included):** state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0.

## Timing
- `start` sampled at edge E0. `busy`=1 from after E0 until after E33 (33 cycles).
- RUN iterations occur at edges E1–E32; FIX at E33.
- `hi`/`lo` take the new values after E33, and `done`=1 for exactly the cycle E33–E34.
- `busy`=0 in the same cycle `done`=1. A new `start` may be accepted at E34, giving back-to-back issue every 34 cycles.
- `busy` and `done` are registered outputs. `hi`/`lo` are register outputs with no combinational path from the inputs.

## Configuration
- MDU_DIV_EN defined: divide datapath and DIV/DIVU supported as above.
- MDU_DIV_EN undefined:
  - Divide logic is not built.
  - A `start` with op[1]=1 is ignored: `busy` stays 0, no `done` pulse, and HI/LO are unchanged.
  - Multiply behaviour and timing are identical to the defined case.

## Structure
- Shared package `mips_pkg`:
  - op encodings MDU_MULTU/MDU_MULT/MDU_DIVU/MDU_DIV;
  - FSM state enum `mdu_state_t` (IDLE/RUN/FIX);
  - constants MDU_ITER=32 and WORD_W=32.
- One sub-module, `mdu_cond_neg`: parameterised-width conditional two's-complement. It is instantiated for operand abs (32-bit) and for the product/quotient/remainder sign fix (64-bit and 32-bit).

## Test plan
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `done` exactly 34 edges after `start`; `busy` high 33 cycles.
- **MULT:** -3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- **DIV/DIVU** (with MDU_DIV_EN):
  - DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 100 / 0 → LO=0xFFFFFFFF, HI=100.
  - DIV 0x80000000 / -1 → LO=0x80000000, HI=0.
- **`cancel` at RUN cycle 10** → `busy` low next edge, HI/LO retain prior values, no `done`. A second `start` while busy is ignored and its operands do not affect the result.
- **Write and reset checks:**
  - `hi_we` with 0x1234 in IDLE → hi=0x1234 next cycle.
  - `lo_we` during busy → lo unchanged.
  - `rst` low mid-RUN → hi=lo=0, `busy`=0 immediately, without waiting for a clock edge.
- **Without MDU_DIV_EN:** `start` with op=DIVU → `busy` stays 0, no `done`; a following MULTU 6×7 → LO=42.
